// File: rtl/downsampler.sv
// Decimating matched filter: N-tap symmetric FIR evaluated once per symbol strobe,
// using N/4 multipliers time-shared over four phases on a snapshot of the tap line.
module downsampler #(
    parameter int N      = 20,
    parameter int N_BY_4 = N / 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sam_clk_ena,
    input  logic               sym_clk_ena,
    input  logic signed [17:0] x_in,
    output logic signed [17:0] y,
    output logic               y_valid,
    output logic               overrun
);

    localparam int AW = $clog2(N);

    localparam logic signed [17:0] COEF [0:19] = '{
        18'sd599,    18'sd764,    -18'sd30,    -18'sd2078,  -18'sd4101,
        -18'sd3432,  18'sd2323,   18'sd13046,  18'sd25177,  18'sd33269,
        18'sd33269,  18'sd25177,  18'sd13046,  18'sd2323,   -18'sd3432,
        -18'sd4101,  -18'sd2078,  -18'sd30,    18'sd764,    18'sd599
    };

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         phase;
    logic signed [17:0] taps [0:N-1];
    logic signed [17:0] snap [0:N-1];
    logic signed [39:0] acc;
    logic signed [39:0] phase_sum;
    logic signed [22:0] acc_shift;
    logic signed [17:0] y_sat;

    // Phase p feeds taps p, p+4, p+8, ... through the shared multipliers.
    always_comb begin
        logic [AW-1:0]      sel;
        logic signed [35:0] prod;
        phase_sum = '0;
        sel       = '0;
        prod      = '0;
        for (int i = 0; i < N_BY_4; i++) begin
            sel       = AW'(4 * i) + AW'(phase);
            prod      = 36'(COEF[sel]) * 36'(snap[sel]);
            phase_sum = phase_sum + 40'(prod);
        end
    end

    assign acc_shift = acc[39:17];

    always_comb begin
        if (acc_shift > 23'sd131071) begin
            y_sat = 18'sd131071;
        end else if (acc_shift < -23'sd131072) begin
            y_sat = -18'sd131072;
        end else begin
            y_sat = acc_shift[17:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sym_clk_ena) state_next = MAC;
            MAC:     if (phase == 2'd3) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The tap line keeps shifting while a snapshot is being processed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                taps[AW'(k)] <= '0;
                snap[AW'(k)] <= '0;
            end
            acc     <= '0;
            phase   <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            if (sam_clk_ena) begin
                taps[0] <= x_in;
                for (int k = 1; k < N; k++) begin
                    taps[AW'(k)] <= taps[AW'(k - 1)];
                end
            end
            case (state)
                IDLE: begin
                    if (sym_clk_ena) begin
                        for (int k = 0; k < N; k++) begin
                            snap[AW'(k)] <= taps[AW'(k)];
                        end
                        acc   <= '0;
                        phase <= '0;
                    end
                end
                MAC: begin
                    acc   <= acc + phase_sum;
                    phase <= phase + 2'd1;
                end
                OUT: begin
                    y       <= y_sat;
                    y_valid <= 1'b1;
                end
                default: ;
            endcase
            if (sym_clk_ena && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
